lcd_byte_tx: RTL
================

// Module: lcd_byte_tx
// PURPOSE
// - Byte-level HD44780 write engine between the display sequencer FSM and the J1 character-LCD header.
// - Takes one command/data byte per start/done handshake; drives RS, D[7:0], EN with bus timing; waits out controller execution time.
// - Ends each byte with a one-cycle done_tick that advances the sequencer. Write-only: RW is tied low on the board.
// PARAMETERS
// - T_SETUP  1      clk cycles RS/D stable before EN rises (tAS >= 40 ns at 10 MHz)
// - T_EN     5      clk cycles EN held high (PWEH >= 230 ns)
// - T_HOLD   2      clk cycles RS/D held after EN falls (tH >= 10 ns)
// - T_EXEC   500    clk cycles wait after a normal command or data byte (>= 37 us)
// - T_LONG   16000  clk cycles wait after clear (0x01) or home (0x02/0x03) (>= 1.52 ms)
// - T_PWRON  400000 clk cycles power-on wait; used only with LCD_PWRON_WAIT_EN (40 ms)
// PORTS
// - clk        in   1  system clock (10 MHz default timing)
// - rst        in   1  asynchronous, active-low reset
// - data       in   8  byte to write; sampled on the accepting edge
// - start      in   1  level request; a byte is accepted when start=1 in IDLE while armed
// - cd         in   1  0 = command (RS=0), 1 = character data (RS=1); sampled with data
// - lcd_d      out  8  LCD data bus
// - lcd_rs     out  1  LCD register select
// - lcd_en     out  1  LCD enable strobe
// - done_tick  out  1  one-cycle pulse: byte written and execution time elapsed
// - busy       out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset (async, rst=0): state IDLE; lcd_d=0, lcd_rs=0, lcd_en=0, done_tick=0, busy=0, armed=1, counter=0. EN drops immediately mid-strobe.
// - All outputs are registered. One shared down-counter, 24 bits wide; every parameter must be <= 2^24-1 and >= 1.
// - States: IDLE -> SETUP -> PULSE -> HOLD -> EXEC -> DONE -> IDLE.
// - IDLE: when start=1 and armed=1, latch data->lcd_d and cd->lcd_rs on that edge, load counter=T_SETUP, go SETUP.
//   Also latch long=(cd==0 && data[7:2]==0 && data!=0).
// - SETUP: count down; at 1, set lcd_en=1, load T_EN, go PULSE.
// - PULSE: count down; at 1, set lcd_en=0, load T_HOLD, go HOLD.
// - HOLD: count down; at 1, load T_LONG if long else T_EXEC, go EXEC. lcd_d/lcd_rs remain unchanged until the next accept.
// - EXEC: count down; at 1, go DONE.
// - DONE: done_tick=1 for exactly this cycle; clear armed; go IDLE.
// - armed is set in any cycle with start=0. A start held high across done_tick is not re-accepted.
//   The sequencer must drop start for >=1 cycle, which the display FSM does by clearing d_start in the done_tick cycle.
// - Latency, accept edge to done_tick: T_SETUP+T_EN+T_HOLD+T_EXEC(or T_LONG)+1 cycles. EN high is exactly T_EN cycles.
// - data/cd changes while busy are ignored. start dropping mid-transfer does not abort.
// - Throughput: next accept is no earlier than 2 cycles after done_tick (IDLE sees start=0, then start=1).
// CONFIGURATION
// - LCD_PWRON_WAIT_EN defined: reset enters state PWRON instead of IDLE, counter=T_PWRON, busy=1.
//   start is ignored until the counter reaches 1, then IDLE. No done_tick is issued for PWRON.
// - LCD_PWRON_WAIT_EN undefined: no PWRON state; reset goes straight to IDLE with busy=0.
//   The top must guarantee the 40 ms LCD power-up delay by other means.
// TESTING
// - Reset with start=1, data=0x38, cd=0, no macro: IDLE accepts on the first edge. lcd_rs=0, lcd_d=0x38.
//   EN high exactly 5 cycles; done_tick one cycle, 509 cycles after accept.
// - cd=0, data=0x01, then data=0x80: 0x01 takes T_LONG (16009 cycles to done_tick); 0x80 takes T_EXEC (509).
//   0x02/0x03 are long; 0x00 and 0x04 are short.
// - cd=1, data="H", start held high continuously: exactly one done_tick and no second EN pulse.
//   Drop start 1 cycle, raise with "E": second transfer with lcd_rs=1, lcd_d=0x45.
// - Change data/cd mid-transfer (in PULSE): lcd_d/lcd_rs unchanged. Assert rst=0 during PULSE: lcd_en=0 with no clock edge; outputs return to reset values.
// - LCD_PWRON_WAIT_EN with T_PWRON=100: busy=1 for 100 cycles after reset; start ignored. First accept on the cycle after busy falls.
// - Replay the 4-byte init plus 33-byte line sequence via a sequencer model: exactly 37 EN pulses, in order, with correct RS per byte.

Source files
------------

// File: rtl/lcd_byte_tx.sv
// HD44780 byte write engine: RS/D setup, EN strobe, hold, then execution wait.
// Define LCD_PWRON_WAIT_EN to add a power-on wait state entered from reset.
module lcd_byte_tx #(
  parameter int T_SETUP = 1,
  parameter int T_EN    = 5,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 500,
  parameter int T_LONG  = 16000,
  parameter int T_PWRON = 400000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  input  logic       cd,
  output logic [7:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       done_tick,
  output logic       busy
);

  localparam int CMAX = 24'hFF_FFFF;

  if (T_SETUP < 1 || T_SETUP > CMAX ||
      T_EN    < 1 || T_EN    > CMAX ||
      T_HOLD  < 1 || T_HOLD  > CMAX ||
      T_EXEC  < 1 || T_EXEC  > CMAX ||
      T_LONG  < 1 || T_LONG  > CMAX ||
      T_PWRON < 1 || T_PWRON > CMAX) begin : g_bad_timing
    $error("lcd_byte_tx: timing parameter outside 1..2^24-1");
  end

  localparam logic [23:0] C_SETUP = 24'(T_SETUP);
  localparam logic [23:0] C_EN    = 24'(T_EN);
  localparam logic [23:0] C_HOLD  = 24'(T_HOLD);
  localparam logic [23:0] C_EXEC  = 24'(T_EXEC);
  localparam logic [23:0] C_LONG  = 24'(T_LONG);
`ifdef LCD_PWRON_WAIT_EN
  localparam logic [23:0] C_PWRON = 24'(T_PWRON);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    DONE,
    PWRON
  } state_t;

  state_t      state;
  logic [23:0] cnt;
  logic        armed;
  logic        long_q;
  logic        last;
  logic        is_long;

  assign last = (cnt == 24'd1);

  // clear and return-home need the long execution wait
  assign is_long = !cd && (data[7:2] == 6'd0) && (data != 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef LCD_PWRON_WAIT_EN
      state <= PWRON;
      cnt   <= C_PWRON;
      busy  <= 1'b1;
`else
      state <= IDLE;
      cnt   <= 24'd0;
      busy  <= 1'b0;
`endif
      lcd_d     <= 8'd0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      done_tick <= 1'b0;
      armed     <= 1'b1;
      long_q    <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      if (!start) begin
        armed <= 1'b1;
      end
      unique case (state)
`ifdef LCD_PWRON_WAIT_EN
        PWRON: begin
          if (last) begin
            cnt   <= 24'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
`endif
        IDLE: begin
          if (start && armed) begin
            lcd_d  <= data;
            lcd_rs <= cd;
            long_q <= is_long;
            cnt    <= C_SETUP;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (last) begin
            lcd_en <= 1'b1;
            cnt    <= C_EN;
            state  <= PULSE;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        PULSE: begin
          if (last) begin
            lcd_en <= 1'b0;
            cnt    <= C_HOLD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        HOLD: begin
          if (last) begin
            cnt   <= long_q ? C_LONG : C_EXEC;
            state <= EXEC;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        EXEC: begin
          if (last) begin
            cnt   <= 24'd0;
            state <= DONE;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        DONE: begin
          // a start still held from this byte must drop before re-accept
          done_tick <= 1'b1;
          armed     <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          lcd_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
